// File: rtl/fmn_axi_arbiter_pkg.sv
// Shared definitions for the FMN 8-to-1 AXI4 arbiter: port count, grant index type,
// and the read/write path state encodings.
package fmn_axi_arbiter_pkg;

  localparam int FMN_NUM_PORTS = 8;
  localparam int FMN_IDX_W     = 3;

  typedef logic [FMN_IDX_W-1:0] port_idx_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rstate_e;

  // Round-robin pointer advance; the 3-bit width makes 7 wrap to 0.
  function automatic port_idx_t next_ptr(input port_idx_t grant);
    return grant + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/fmn_axi_arbiter_rr.sv
// Combinational round-robin pick: first requesting index at or after ptr_i,
// searching upward with wrap from 7 to 0.
module fmn_rr_arbiter
  import fmn_axi_arbiter_pkg::*;
(
  input  logic [7:0] req_i,
  input  logic [2:0] ptr_i,
  input  logic       en_i,
  output logic [2:0] idx_o,
  output logic       any_req_o
);

  always_comb begin
    logic [2:0] cand;
    idx_o     = ptr_i;
    any_req_o = 1'b0;
    cand      = ptr_i;
    // Walk from farthest offset down so the nearest requester wins last.
    for (int i = FMN_NUM_PORTS - 1; i >= 0; i--) begin
      cand = ptr_i + 3'(i);
      if (en_i && req_i[cand]) begin
        idx_o     = cand;
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmn_axi_arbiter.sv
// Merges eight vectored AXI4 slave ports onto one master port with independent
// round-robin arbitration on the write and read paths, one transaction per path.
module fmn_axi_arbiter
  import fmn_axi_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  // Vectored slave side, port k in slice k
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    SN_awaddr,
  input  logic [NUM_PORTS*8-1:0]             SN_awlen,
  input  logic [NUM_PORTS*3-1:0]             SN_awsize,
  input  logic [NUM_PORTS*2-1:0]             SN_awburst,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]      SN_awid,
  input  logic [NUM_PORTS-1:0]               SN_awvalid,
  output logic [NUM_PORTS-1:0]               SN_awready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    SN_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  SN_wstrb,
  input  logic [NUM_PORTS-1:0]               SN_wlast,
  input  logic [NUM_PORTS-1:0]               SN_wvalid,
  output logic [NUM_PORTS-1:0]               SN_wready,
  output logic [NUM_PORTS*2-1:0]             SN_bresp,
  output logic [NUM_PORTS*ID_WIDTH-1:0]      SN_bid,
  output logic [NUM_PORTS-1:0]               SN_bvalid,
  input  logic [NUM_PORTS-1:0]               SN_bready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    SN_araddr,
  input  logic [NUM_PORTS*8-1:0]             SN_arlen,
  input  logic [NUM_PORTS*3-1:0]             SN_arsize,
  input  logic [NUM_PORTS*2-1:0]             SN_arburst,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]      SN_arid,
  input  logic [NUM_PORTS-1:0]               SN_arvalid,
  output logic [NUM_PORTS-1:0]               SN_arready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]    SN_rdata,
  output logic [NUM_PORTS*2-1:0]             SN_rresp,
  output logic [NUM_PORTS*ID_WIDTH-1:0]      SN_rid,
  output logic [NUM_PORTS-1:0]               SN_rlast,
  output logic [NUM_PORTS-1:0]               SN_rvalid,
  input  logic [NUM_PORTS-1:0]               SN_rready,
  // Single master side
  output logic [ADDR_WIDTH-1:0]              M_awaddr,
  output logic [7:0]                         M_awlen,
  output logic [2:0]                         M_awsize,
  output logic [1:0]                         M_awburst,
  output logic [ID_WIDTH-1:0]                M_awid,
  output logic                               M_awvalid,
  input  logic                               M_awready,
  output logic [DATA_WIDTH-1:0]              M_wdata,
  output logic [DATA_WIDTH/8-1:0]            M_wstrb,
  output logic                               M_wlast,
  output logic                               M_wvalid,
  input  logic                               M_wready,
  input  logic [1:0]                         M_bresp,
  input  logic [ID_WIDTH-1:0]                M_bid,
  input  logic                               M_bvalid,
  output logic                               M_bready,
  output logic [ADDR_WIDTH-1:0]              M_araddr,
  output logic [7:0]                         M_arlen,
  output logic [2:0]                         M_arsize,
  output logic [1:0]                         M_arburst,
  output logic [ID_WIDTH-1:0]                M_arid,
  output logic                               M_arvalid,
  input  logic                               M_arready,
  input  logic [DATA_WIDTH-1:0]              M_rdata,
  input  logic [1:0]                         M_rresp,
  input  logic [ID_WIDTH-1:0]                M_rid,
  input  logic                               M_rlast,
  input  logic                               M_rvalid,
  output logic                               M_rready,
  // Debug visibility of both path FSMs and their pointers
  output logic [1:0]                         dbg_wstate_o,
  output logic [1:0]                         dbg_rstate_o,
  output logic [2:0]                         dbg_wptr_o,
  output logic [2:0]                         dbg_rptr_o
);

  localparam int SW = DATA_WIDTH / 8;

  // Handshakes: a beat transfers on a cycle where valid && ready; valid never waits
  // on ready, and only the granted slice ever sees ready/valid driven from this block.

  wstate_e   wstate_q, wstate_d;
  rstate_e   rstate_q, rstate_d;
  port_idx_t wgrant_q, wgrant_d, wptr_q, wptr_d;
  port_idx_t rgrant_q, rgrant_d, rptr_q, rptr_d;
  port_idx_t w_idx, r_idx;
  logic      w_any, r_any;

  fmn_rr_arbiter u_warb (
    .req_i     (SN_awvalid),
    .ptr_i     (wptr_q),
    .en_i      (wstate_q == W_IDLE),
    .idx_o     (w_idx),
    .any_req_o (w_any)
  );

  fmn_rr_arbiter u_rarb (
    .req_i     (SN_arvalid),
    .ptr_i     (rptr_q),
    .en_i      (rstate_q == R_IDLE),
    .idx_o     (r_idx),
    .any_req_o (r_any)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q <= W_IDLE;
      wgrant_q <= '0;
      wptr_q   <= '0;
      rstate_q <= R_IDLE;
      rgrant_q <= '0;
      rptr_q   <= '0;
    end else begin
      wstate_q <= wstate_d;
      wgrant_q <= wgrant_d;
      wptr_q   <= wptr_d;
      rstate_q <= rstate_d;
      rgrant_q <= rgrant_d;
      rptr_q   <= rptr_d;
    end
  end

  // Payload muxing is unconditional; only valid/ready depend on the state.
  assign M_awaddr  = SN_awaddr [int'(wgrant_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign M_awlen   = SN_awlen  [int'(wgrant_q)*8 +: 8];
  assign M_awsize  = SN_awsize [int'(wgrant_q)*3 +: 3];
  assign M_awburst = SN_awburst[int'(wgrant_q)*2 +: 2];
  assign M_awid    = SN_awid   [int'(wgrant_q)*ID_WIDTH +: ID_WIDTH];
  assign M_wdata   = SN_wdata  [int'(wgrant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign M_wstrb   = SN_wstrb  [int'(wgrant_q)*SW +: SW];
  assign M_wlast   = SN_wlast  [wgrant_q];
  assign M_araddr  = SN_araddr [int'(rgrant_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign M_arlen   = SN_arlen  [int'(rgrant_q)*8 +: 8];
  assign M_arsize  = SN_arsize [int'(rgrant_q)*3 +: 3];
  assign M_arburst = SN_arburst[int'(rgrant_q)*2 +: 2];
  assign M_arid    = SN_arid   [int'(rgrant_q)*ID_WIDTH +: ID_WIDTH];

  assign SN_bresp = {NUM_PORTS{M_bresp}};
  assign SN_bid   = {NUM_PORTS{M_bid}};
  assign SN_rdata = {NUM_PORTS{M_rdata}};
  assign SN_rresp = {NUM_PORTS{M_rresp}};
  assign SN_rid   = {NUM_PORTS{M_rid}};
  assign SN_rlast = {NUM_PORTS{M_rlast}};

  always_comb begin
    wstate_d   = wstate_q;
    wgrant_d   = wgrant_q;
    wptr_d     = wptr_q;
    M_awvalid  = 1'b0;
    M_wvalid   = 1'b0;
    M_bready   = 1'b0;
    SN_awready = '0;
    SN_wready  = '0;
    SN_bvalid  = '0;
    case (wstate_q)
      W_IDLE: begin
        if (w_any) begin
          wgrant_d = w_idx;
          wstate_d = W_ADDR;
        end
      end
      W_ADDR: begin
        M_awvalid            = SN_awvalid[wgrant_q];
        SN_awready[wgrant_q] = M_awready;
        if (SN_awvalid[wgrant_q] && M_awready) wstate_d = W_DATA;
      end
      W_DATA: begin
        M_wvalid            = SN_wvalid[wgrant_q];
        SN_wready[wgrant_q] = M_wready;
        if (SN_wvalid[wgrant_q] && M_wready && SN_wlast[wgrant_q]) wstate_d = W_RESP;
      end
      W_RESP: begin
        SN_bvalid[wgrant_q] = M_bvalid;
        M_bready            = SN_bready[wgrant_q];
        if (M_bvalid && SN_bready[wgrant_q]) begin
          wstate_d = W_IDLE;
          wptr_d   = next_ptr(wgrant_q);
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d   = rstate_q;
    rgrant_d   = rgrant_q;
    rptr_d     = rptr_q;
    M_arvalid  = 1'b0;
    M_rready   = 1'b0;
    SN_arready = '0;
    SN_rvalid  = '0;
    case (rstate_q)
      R_IDLE: begin
        if (r_any) begin
          rgrant_d = r_idx;
          rstate_d = R_ADDR;
        end
      end
      R_ADDR: begin
        M_arvalid            = SN_arvalid[rgrant_q];
        SN_arready[rgrant_q] = M_arready;
        if (SN_arvalid[rgrant_q] && M_arready) rstate_d = R_DATA;
      end
      R_DATA: begin
        SN_rvalid[rgrant_q] = M_rvalid;
        M_rready            = SN_rready[rgrant_q];
        if (M_rvalid && SN_rready[rgrant_q] && M_rlast) begin
          rstate_d = R_IDLE;
          rptr_d   = next_ptr(rgrant_q);
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign dbg_wstate_o = wstate_q;
  assign dbg_rstate_o = rstate_q;
  assign dbg_wptr_o   = wptr_q;
  assign dbg_rptr_o   = rptr_q;

endmodule

// File: doc/fmn_axi_arbiter.md
# fmn_axi_arbiter

Merges the eight per-port AXI4 memory-mapped masters of the FMN interconnect back into a single master port: the N-to-1 counterpart of the vector-splitting collector. Read and write paths each have an independent round-robin arbiter. A winning port holds its path until its transaction fully completes, so there is one outstanding transaction per direction. It sits between the eight FMN port masters and the single upstream AXI Interconnect slave port.

## Interface
Parameters:
- NUM_PORTS, 8, number of slave ports; fixed at 8, with a 3-bit grant index.
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; WSTRB width is DATA_WIDTH/8.
- ID_WIDTH, 1, AXI ID width; IDs pass through unchanged.

Ports:
- aclk, in, 1, the only clock.
- aresetn, in, 1, asynchronous active-low reset.
- SN_aw{addr,len,size,burst,id,valid} / SN_awready, in / out, NUM_PORTS×field, vectored slave AW channels; port k occupies slice k.
- SN_w{data,strb,last,valid} / SN_wready, in / out, NUM_PORTS×field, vectored W channels.
- SN_b{resp,id,valid} / SN_bready, out / in, NUM_PORTS×field, vectored B channels.
- SN_ar{addr,len,size,burst,id,valid} / SN_arready, in / out, NUM_PORTS×field, vectored AR channels.
- SN_r{data,resp,id,last,valid} / SN_rready, out / in, NUM_PORTS×field, vectored R channels.
- M_aw*, M_w*, M_b*, M_ar*, M_r*, mixed, 1×field, single AXI4 master port with the mirrored directions.

## Operation
- The write path FSM has four states: W_IDLE → W_ADDR → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: when any SN_awvalid[k] is set, latch the round-robin winner into wgrant and go to W_ADDR.
  - W_ADDR: drive M_aw* from slice wgrant, with M_awvalid = SN_awvalid[wgrant] and SN_awready[wgrant] = M_awready. On the AW handshake, go to W_DATA.
  - W_DATA: route W from slice wgrant. On a handshake with wlast=1, go to W_RESP.
  - W_RESP: route M_b* to slice wgrant and pass M_bready through. On the B handshake, go to W_IDLE and set wptr = wgrant+1 (mod 8).
- The read path FSM has three states: R_IDLE → R_ADDR → R_DATA → R_IDLE.
  - It mirrors the write path using AR and R, with rgrant and rptr.
  - R_DATA exits on an R handshake with rlast=1.
- Round-robin rule: the winner is the first requesting index at or after the pointer, searching upward with wrap from 7 to 0.
- Non-granted ports:
  - SN_*ready and SN_bvalid/SN_rvalid are held at 0.
  - Their data outputs are don't-care but must not be X; drive them with the M_ data replicated.
- The read and write paths are fully independent. They may grant different ports or the same port at the same time.
- A W beat presented before its AW has been granted stalls, because wready stays 0 until W_DATA. A W beat presented in W_ADDR also stalls.

## Timing
- Reset value of every output is 0: all M_*valid, M_bready, M_rready, SN_*ready, SN_bvalid and SN_rvalid. Pointers are 0 and both FSMs are in IDLE.
- Arbitration latency is 1 cycle. If SN_awvalid[k] rises in cycle n while in IDLE, M_awvalid is 1 in cycle n+1. The same holds for AR.
- All forwarding after the grant is combinational, with zero added latency per beat. Throughput is full rate within a burst.
- After a completing B or RLAST handshake in cycle n, the FSM is IDLE in cycle n+1. The earliest next grant is visible in n+2.
- Simultaneous requests: only the pointer-ordered winner is granted. The others keep valid asserted and wait.
  - Example: wptr=0 with requests on {2,5} grants 2, then 5.
- Pointer wrap: wgrant=7 completing sets wptr=0.
- A requester that drops valid before its grant is simply skipped. Dropping valid after the grant is a protocol violation and is not handled.
- Reset mid-transaction: on aresetn low, all outputs go to 0 asynchronously, the FSMs return to IDLE and the pointers reset. Any in-flight burst is abandoned.

## Structure
- The shared header fmn_axi_pkg.vh holds:
  - the FSM state encodings (W_IDLE..W_RESP, R_IDLE..R_DATA);
  - NUM_PORTS and its log2 width;
  - the slice macros for vector field k.
- The sub-module fmn_rr_arbiter takes an 8-bit request, a 3-bit pointer and a grant-enable. It outputs a 3-bit index and an any_req flag. It is instantiated once for write and once for read.
- The signal bundles come from the existing mem_axi.vh port macros.

## Test plan
- Single write: port 3 issues AW addr=0x1000 with len=3 and 4 W beats → M_aw* shows addr 0x1000 one cycle after awvalid, 4 beats pass, B OKAY is returned only on SN_bvalid[3], and wptr becomes 4.
- Contention: ports 1, 4 and 6 assert AR together with rptr=0 → grants occur in order 1, 4, 6, and each R burst returns only to its own port.
- Wrap: port 7 completes a write, then ports 0 and 7 both request → port 0 is granted first.
- Concurrency: port 2 writes while port 5 reads at the same time → both complete with no cross-routing and no added stall.
- Early W / backpressure: port 0 presents W before AW, with M_awready held 0 for 5 cycles → SN_wready[0] stays 0 until after the AW handshake, and there is no data loss.
- Reset mid-burst: aresetn is pulled low during beat 2 of a 4-beat read → all outputs go to 0 immediately, and after release a fresh port-0 read is granted normally.
